rf_wb_sched: RTL and testbench



---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_scoreboard.sv | 55 +++++
 rtl/rf_wb_sched.sv | 144 ++++++++++++++
 tb/tb_rf_wb_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file package: address/data widths and typedefs used by the
// RF, the issue logic and the write-back scheduler.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    // One-hot select of a register index across the whole file
    function automatic logic [REG_COUNT-1:0] reg_onehot(input reg_addr_t addr);
        logic [REG_COUNT-1:0] one;
        one = {{(REG_COUNT-1){1'b0}}, 1'b1};
        return one << addr;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for registers reserved by long-latency (B) ops.
// A claim sets the bit, the B write leaving the write stage clears it; a set
// and a clear of the same bit in one cycle leaves the bit set. r0 never pends.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       claim_valid,
    input  logic [4:0] claim_rd,
    input  logic       clr_en,
    input  logic [4:0] clr_addr,
    input  logic [4:0] rs_addr,
    input  logic [4:0] rt_addr,
    input  logic [4:0] lookup_addr,
    output logic       claim_ready,
    output logic       lookup_pending,
    output logic       src_hazard
);

    logic [REG_COUNT-1:0] pending_q;
    logic [REG_COUNT-1:0] pending_d;
    logic                 set_en;

    // Lookups against the current pending set
    always_comb begin
        claim_ready    = !pending_q[claim_rd];
        lookup_pending = pending_q[lookup_addr];
        src_hazard     = pending_q[rs_addr] | pending_q[rt_addr]
                       | (claim_valid && !claim_ready);
    end

    // Next pending set: clear first so a same-cycle set of that bit wins
    always_comb begin
        set_en    = claim_valid && claim_ready && (claim_rd != 5'd0);
        pending_d = pending_q;
        if (clr_en) begin
            pending_d = pending_d & ~reg_onehot(clr_addr);
        end
        if (set_en) begin
            pending_d = pending_d | reg_onehot(claim_rd);
        end
        pending_d[0] = 1'b0;
    end

    // Pending bit storage; reset drops all outstanding claims
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/rf_wb_sched.sv
// Register-file write-back scheduler. Arbitrates the single RF write port
// between the in-order pipeline (A) and the long-latency unit (B), with a
// starvation bound for B, and flags issue hazards from the claim scoreboard.
// Optional build macro RF_WB_FWD_EN: adds rs_fwd/rt_fwd/fwd_data forwarding
// outputs from the write stage; without it, a source matching the register
// being written this cycle raises hazard instead.
module rf_wb_sched
    import rf_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    input  logic        claim_valid,
    output logic        claim_ready,
    input  logic [4:0]  claim_rd,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        hazard,
    output logic        RegWrite,
    output logic [4:0]  RdAddr,
    output logic [31:0] RdData,
`ifdef RF_WB_FWD_EN
    output logic        rs_fwd,
    output logic        rt_fwd,
    output logic [31:0] fwd_data,
`endif
    output logic        sb_err
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             wb_valid_q, wb_valid_d;
    logic             wb_is_b_q, wb_is_b_d;
    logic             reg_write_q, reg_write_d;
    reg_addr_t        wb_rd_q, wb_rd_d;
    reg_data_t        wb_data_q, wb_data_d;
    logic             sb_err_q, sb_err_d;

    logic             starve_hit;
    logic             a_xfer, b_xfer;
    logic             b_pending;
    logic             sb_hazard;

    // Scoreboard: B writes retire their claim as they leave the write stage
    rf_scoreboard u_sb (
        .clk            (clk),
        .rst            (rst),
        .claim_valid    (claim_valid),
        .claim_rd       (claim_rd),
        .clr_en         (wb_valid_q && wb_is_b_q),
        .clr_addr       (wb_rd_q),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .lookup_addr    (b_rd),
        .claim_ready    (claim_ready),
        .lookup_pending (b_pending),
        .src_hazard     (sb_hazard)
    );

    // Arbitration: A by default, B when A is idle or B has waited its limit
    always_comb begin
        starve_hit = (starve_q == STARVE_LIM);
        b_ready    = b_valid && (!a_valid || starve_hit);
        a_ready    = a_valid && !b_ready;
        a_xfer     = a_valid && a_ready;
        b_xfer     = b_valid && b_ready;
    end

    // Next-state for starve counter, write stage and sticky error
    always_comb begin
        starve_d = starve_q;
        if (!b_valid || b_ready) begin
            starve_d = '0;
        end else if (!starve_hit) begin
            starve_d = starve_q + 1'b1;
        end

        wb_valid_d  = a_xfer || b_xfer;
        wb_is_b_d   = b_xfer;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        if (b_xfer) begin
            wb_rd_d   = b_rd;
            wb_data_d = b_data;
        end else if (a_xfer) begin
            wb_rd_d   = a_rd;
            wb_data_d = a_data;
        end
        // r0 writes pass through the stage but never reach the RF
        reg_write_d = wb_valid_d && (wb_rd_d != 5'd0);

        sb_err_d = sb_err_q | (b_xfer && (b_rd != 5'd0) && !b_pending);
    end

    // State registers; reset discards any in-flight write
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_is_b_q   <= 1'b0;
            reg_write_q <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            wb_valid_q  <= wb_valid_d;
            wb_is_b_q   <= wb_is_b_d;
            reg_write_q <= reg_write_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            sb_err_q    <= sb_err_d;
        end
    end

    // RF port, forwarding and issue hazard
    always_comb begin
        RegWrite = reg_write_q;
        RdAddr   = wb_rd_q;
        RdData   = wb_data_q;
        sb_err   = sb_err_q;
`ifdef RF_WB_FWD_EN
        rs_fwd   = reg_write_q && (wb_rd_q == rs_addr);
        rt_fwd   = reg_write_q && (wb_rd_q == rt_addr);
        fwd_data = wb_data_q;
        hazard   = sb_hazard;
`else
        hazard   = sb_hazard
                 | (reg_write_q && ((wb_rd_q == rs_addr) || (wb_rd_q == rt_addr)));
`endif
    end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched: expected RF writes are queued as stimulus is
// driven and checked in order as RegWrite pulses appear.
module tb_rf_wb_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid, b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        claim_valid, claim_ready;
    logic [4:0]  claim_rd;
    logic [4:0]  rs_addr, rt_addr;
    logic        hazard;
    logic        RegWrite;
    logic [4:0]  RdAddr;
    logic [31:0] RdData;
    logic        sb_err;
`ifdef RF_WB_FWD_EN
    logic        rs_fwd, rt_fwd;
    logic [31:0] fwd_data;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    rf_wb_sched #(.STARVE_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_rd        (a_rd),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_rd        (b_rd),
        .b_data      (b_data),
        .claim_valid (claim_valid),
        .claim_ready (claim_ready),
        .claim_rd    (claim_rd),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .hazard      (hazard),
        .RegWrite    (RegWrite),
        .RdAddr      (RdAddr),
        .RdData      (RdData),
`ifdef RF_WB_FWD_EN
        .rs_fwd      (rs_fwd),
        .rt_fwd      (rt_fwd),
        .fwd_data    (fwd_data),
`endif
        .sb_err      (sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        if (rd != 5'd0) exp_q.push_back(w);
    endtask

    // Write-port monitor: every RF write must match the oldest expected one
    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL wr_unexpected observed rd=%0d data=%0h expected no write", RdAddr, RdData);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_rd", {27'd0, RdAddr}, {27'd0, w.rd});
                check("wr_data", RdData, w.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        claim_valid = 0; claim_rd = 0;
        rs_addr = 0; rt_addr = 0;
        tick();
        tick();
        settle();
        check("rst_regwrite", RegWrite, 0);
        check("rst_rdaddr", RdAddr, 0);
        check("rst_rddata", RdData, 0);
        check("rst_sberr", sb_err, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_hazard", hazard, 0);
        tick();
        rst = 1'b0;

        // Simple A write, one-cycle latency
        a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
        settle();
        check("a1_a_ready", a_ready, 1);
        check("a1_b_ready", b_ready, 0);
        push(5, 32'hDEADBEEF);
        tick();
        a_valid = 0;
        settle();
        check("a1_regwrite", RegWrite, 1);
        check("a1_rdaddr", RdAddr, 5);
        check("a1_rddata", RdData, 32'hDEADBEEF);
        tick();

        // Reserve r10 for the B writes in the starvation run
        claim_valid = 1; claim_rd = 10;
        settle();
        check("claim10_ready", claim_ready, 1);
        tick();
        claim_valid = 0;

        // Both requesters busy: A,A,A,A then B, then A again
        a_valid = 1; b_valid = 1; b_rd = 10; b_data = 32'hB0B00001;
        for (int k = 0; k < 6; k++) begin
            logic exp_b;
            a_rd   = 5'(k + 1);
            a_data = 32'h100 + k;
            exp_b  = (k == 4);
            settle();
            check($sformatf("starve%0d_a_ready", k), a_ready, !exp_b);
            check($sformatf("starve%0d_b_ready", k), b_ready, exp_b);
            if (exp_b) push(b_rd, b_data);
            else       push(a_rd, a_data);
            tick();
        end
        a_valid = 0; b_valid = 0;
        tick();
        tick();
        check("starve_sberr", sb_err, 0);

        // Claim r7, source hazard, refused second claim, release by B write
        claim_valid = 1; claim_rd = 7;
        settle();
        check("claim7_ready", claim_ready, 1);
        tick();
        claim_valid = 0; rs_addr = 7;
        settle();
        check("claim7_hazard", hazard, 1);
        tick();
        claim_valid = 1; claim_rd = 7;
        settle();
        check("claim7_again_ready", claim_ready, 0);
        check("claim7_again_hazard", hazard, 1);
        tick();
        claim_valid = 0; b_valid = 1; b_rd = 7; b_data = 32'h77777777;
        settle();
        check("b7_b_ready", b_ready, 1);
        push(7, 32'h77777777);
        tick();
        b_valid = 0;
        settle();
        check("b7_hazard_n1", hazard, 1);
        tick();
        settle();
        check("b7_hazard_n2", hazard, 0);
        check("b7_sberr", sb_err, 0);
        tick();
        rs_addr = 0;

        // r0: accepted, never written, never claimed
        a_valid = 1; a_rd = 0; a_data = 32'h12345;
        settle();
        check("r0_a_ready", a_ready, 1);
        tick();
        a_valid = 0; claim_valid = 1; claim_rd = 0;
        settle();
        check("r0_regwrite", RegWrite, 0);
        check("r0_claim_ready", claim_ready, 1);
        check("r0_hazard", hazard, 0);
        tick();
        claim_valid = 0;
        settle();
        check("r0_hazard_after", hazard, 0);
        tick();

        // Unclaimed B write: still written, sticky error
        b_valid = 1; b_rd = 9; b_data = 32'h99999999;
        settle();
        check("b9_b_ready", b_ready, 1);
        push(9, 32'h99999999);
        tick();
        b_valid = 0;
        settle();
        check("b9_sberr", sb_err, 1);
        tick();

        // Clear and claim of r3 on the same edge: claim survives
        b_valid = 1; b_rd = 3; b_data = 32'h33333333;
        settle();
        check("b3_b_ready", b_ready, 1);
        push(3, 32'h33333333);
        tick();
        b_valid = 0; claim_valid = 1; claim_rd = 3;
        settle();
        check("b3_claim_ready", claim_ready, 1);
        tick();
        claim_valid = 0; rs_addr = 3;
        settle();
        check("b3_pending_hazard", hazard, 1);
        check("b3_pending_ready", claim_ready, 0);
        check("b3_sberr_sticky", sb_err, 1);
        tick();
        rs_addr = 0;

        // Source matches the register being written this cycle
        a_valid = 1; a_rd = 12; a_data = 32'hCAFEF00D;
        settle();
        push(12, 32'hCAFEF00D);
        tick();
        a_valid = 0; rs_addr = 12; rt_addr = 12;
        settle();
`ifdef RF_WB_FWD_EN
        check("fwd_rs", rs_fwd, 1);
        check("fwd_rt", rt_fwd, 1);
        check("fwd_data", fwd_data, 32'hCAFEF00D);
        check("fwd_hazard", hazard, 0);
`else
        check("match_hazard", hazard, 1);
`endif
        tick();
        settle();
        check("match_hazard_after", hazard, 0);
        tick();
        rs_addr = 0; rt_addr = 0;

        // Reset with a write in flight: dropped, claims and error cleared
        a_valid = 1; a_rd = 13; a_data = 32'h13131313; rst = 1;
        tick();
        a_valid = 0; rst = 0; rs_addr = 3; claim_rd = 3;
        settle();
        check("rst2_regwrite", RegWrite, 0);
        check("rst2_sberr", sb_err, 0);
        check("rst2_hazard", hazard, 0);
        check("rst2_claim_ready", claim_ready, 1);
        tick();
        tick();

        check("wr_queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
